// File: rtl/seven_segment_arbiter_if.sv
// Display-sharing bus: requesters present level requests and 16-bit values,
// the arbiter returns the grant and the scanned seven-segment drive.
interface seven_segment_arbiter_if #(
  parameter int n_sources = 4
);
  logic [n_sources-1:0]    req;
  logic [n_sources*16-1:0] data;
  logic [n_sources-1:0]    grant;
  logic [2:0]              active_src;
  logic                    busy;
  logic [7:0]              abcdefgh;
  logic [3:0]              digit;

  modport master (
    output req, data,
    input  grant, active_src, busy, abcdefgh, digit
  );

  modport slave (
    input  req, data,
    output grant, active_src, busy, abcdefgh, digit
  );
endinterface

// File: rtl/seven_segment_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold time, plus a
// free-running digit scan and hex decode of the owner's value.
module seven_segment_arbiter #(
  parameter int n_sources                  = 4,
  parameter int hold_cycles                = 1000,
  parameter int seven_segment_strobe_width = 1024
) (
  input logic clk,
  input logic reset_n,
  seven_segment_arbiter_if.slave bus
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              ptr, owner, owner_nxt, winner;
  logic                    found;
  logic [31:0]             hold_cnt, hold_nxt, strobe_cnt;
  logic                    strobe_wrap;
  logic [1:0]              scan_idx, scan_nxt;
  logic [15:0]             disp;
  logic [3:0]              nib;
  logic [7:0]              seg, seg_nxt;
  logic [3:0]              digit_q;
  logic [n_sources-1:0]    grant_q, rot;
  logic [2*n_sources-1:0]  req2;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'b11111100;
      4'h1: return 8'b01100000;
      4'h2: return 8'b11011010;
      4'h3: return 8'b11110010;
      4'h4: return 8'b01100110;
      4'h5: return 8'b10110110;
      4'h6: return 8'b10111110;
      4'h7: return 8'b11100000;
      4'h8: return 8'b11111110;
      4'h9: return 8'b11110110;
      4'hA: return 8'b11101110;
      4'hB: return 8'b00111110;
      4'hC: return 8'b10011100;
      4'hD: return 8'b01111010;
      4'hE: return 8'b10011110;
      default: return 8'b10001110;
    endcase
  endfunction

  // Rotate requests so bit 0 is the source right after the pointer; the
  // pointer itself lands last, which makes "keep the owner" the fallback.
  always_comb begin
    req2   = {bus.req, bus.req};
    rot    = n_sources'(req2 >> (ptr + 3'd1));
    found  = 1'b0;
    winner = ptr;
    for (int j = 0; j < n_sources; j++) begin
      if (!found && rot[j]) begin
        found  = 1'b1;
        winner = 3'((int'(ptr) + 1 + j) % n_sources);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold_cnt + 32'd1;
    case (state)
      IDLE: begin
        hold_nxt = 32'd0;
        if (found) begin
          state_nxt = SHOW;
          owner_nxt = winner;
        end
      end
      SHOW: begin
        if (hold_cnt == 32'(hold_cycles - 1)) begin
          hold_nxt = 32'd0;
          if (found) begin
            owner_nxt = winner;
          end else begin
            state_nxt = IDLE;
            owner_nxt = 3'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Segments are blanked whenever this or the next cycle is idle.
  always_comb begin
    strobe_wrap = (strobe_cnt == 32'(seven_segment_strobe_width - 1));
    scan_nxt    = strobe_wrap ? scan_idx + 2'd1 : scan_idx;
    nib         = 4'(disp >> {scan_nxt, 2'b00});
    seg_nxt     = 8'd0;
    if (state == SHOW && state_nxt == SHOW) begin
      seg_nxt = hex_to_seg(nib);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 3'd0;
      ptr      <= 3'(n_sources - 1);
      hold_cnt <= 32'd0;
      grant_q  <= '0;
      disp     <= 16'd0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      if (state_nxt == SHOW) begin
        ptr     <= owner_nxt;
        grant_q <= {{(n_sources-1){1'b0}}, 1'b1} << owner_nxt;
        if (bus.req[owner_nxt]) begin
          disp <= 16'(bus.data >> {owner_nxt, 4'b0000});
        end
      end else begin
        grant_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_cnt <= 32'd0;
      scan_idx   <= 2'd0;
      digit_q    <= 4'b0001;
      seg        <= 8'd0;
    end else begin
      strobe_cnt <= strobe_wrap ? 32'd0 : strobe_cnt + 32'd1;
      scan_idx   <= scan_nxt;
      digit_q    <= 4'b0001 << scan_nxt;
      seg        <= seg_nxt;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.active_src = owner;
  assign bus.busy       = (state == SHOW);
  assign bus.abcdefgh   = seg;
  assign bus.digit      = digit_q;

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Shares the board's 4-digit seven-segment display between up to `n_sources` requesters such as a counter, a shift-register view or a debug monitor. It grants the display round-robin with a guaranteed minimum ownership time. It also scans and hex-decodes the granted 16-bit value onto `abcdefgh` / `digit`. It sits between the functional blocks and the board top level, which performs any pin-polarity inversion.

## Interface

- `n_sources`, 4, number of requesters (2..8)
- `hold_cycles`, 1000, minimum clock cycles a grant is held (>= 1)
- `seven_segment_strobe_width`, 1024, clock cycles each digit stays lit per scan step (>= 1)

- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  n_sources  per-source display request, level
- `data`  in  n_sources*16  source i value at bits [16i+15:16i], four hex nibbles
- `grant`  out  n_sources  one-hot current owner, all-zero when idle
- `active_src`  out  3  index of the current owner, 0 when idle
- `busy`  out  1  high while any grant is held
- `abcdefgh`  out  8  segments a..g plus decimal point h, active-high
- `digit`  out  4  one-hot digit enable, active-high, bit 0 = rightmost

## Operation

- FSM states IDLE and SHOW.
- **IDLE**
  - `grant` = 0 and segments are blank.
  - If any `req` is high, pick a winner by round-robin and go to SHOW.
- **SHOW**
  - Hold counter counts 0..hold_cycles-1 from the grant cycle.
  - While the owner's `req` is high, its `data` slice is copied into the display register every cycle.
  - When the owner drops `req`, the last copied value stays frozen.
  - At hold expiry (counter = hold_cycles-1), re-arbitrate:
    - another source requesting: grant the next one in round-robin order after the current owner;
    - otherwise, owner still requesting: keep the grant and restart the hold counter;
    - otherwise: go to IDLE.
- Round-robin pointer = last owner. The search starts at pointer+1 and wraps modulo `n_sources`. The pointer resets to n_sources-1, so index 0 wins the first contention.
- An owner is never pre-empted before `hold_cycles` elapse, even if its `req` drops early.
- **Scan**
  - A free-running strobe counter advances the digit index every `seven_segment_strobe_width` cycles.
  - Index sequence is 0,1,2,3,0,...
  - The scan runs in all states, including IDLE.
- **Decode**
  - Nibble [4k+3:4k] of the display register drives digit k.
  - Standard hex patterns, abcdefgh order with a at MSB: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110, A=11101110, b=00111110, C=10011100, d=01111010, E=10011110, F=10001110.
  - h is always 0.
  - In IDLE, `abcdefgh` = 0.
- All outputs are registered.

## Timing

- Reset (async assert, sync release) sets:
  - state IDLE, `grant` 0, `active_src` 0, `busy` 0, `abcdefgh` 0, `digit` 4'b0001;
  - scan index 0, strobe counter 0, pointer n_sources-1, display register 0.
- Request to grant: `req` sampled high at edge N in IDLE gives `grant`/`busy` high after edge N+1 (1 cycle).
- Handover at expiry is gapless: the old grant drops and the new grant rises at the same edge, with no IDLE cycle between owners.
- Minimum grant length is `hold_cycles` cycles; a re-granted owner gets another full `hold_cycles`.
- Segment latency: `abcdefgh` reflects the display register and scan index of the previous cycle. A newly granted source's value appears one cycle after `grant` rises.
- `digit` changes on the same edge as the scan index register, so `digit` and `abcdefgh` are aligned.
- Reset asserted mid-grant drops `grant` and blanks segments immediately (asynchronous). The pointer also resets, so fairness history is lost.
- `req` of a non-owner that pulses and drops before expiry is ignored; no request latching.

## Test plan

Parameters for all scenarios: n_sources=4, hold_cycles=4, seven_segment_strobe_width=1.

- **Reset:** hold `reset_n`=0 for 2 cycles, then release -> `grant`=0, `busy`=0, `abcdefgh`=0, `digit` cycles 0001,0010,0100,1000,0001.
- **Single request:** req=0100, data[47:32]=16'h1230 -> `grant`=0100 one cycle later, held at least 4 cycles; the scan shows 11111100 (0) with digit 0001, then 11110010 (3), 11011010 (2), 01100000 (1).
- **Contention after reset:** req=1111 from IDLE -> grants 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles long with no gap.
- **Early drop:** source 1 granted with 16'hABCD, `req`[1] drops after 1 cycle -> segments keep showing A, b, C, d until expiry, then IDLE and blank.
- **Re-grant:** only source 3 requesting continuously -> `grant` stays 1000 with no gap, and the hold counter restarts every 4 cycles.
- **Mid-grant reset:** `reset_n` pulsed low during a grant of source 2 -> outputs cleared in the same cycle; after release with req=0110, source 1 wins first.
